// File: rtl/spi_host_master_pkg.sv
// Shared types and helpers for the SPI host master.
// Holds the FSM state encoding and the counter width helper.
package spi_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_LINGER,
        ST_GAP
    } state_e;

    localparam int SPI_MODE = 0;

    // Width of a counter that must count 0..max(a,b,c,d)-1
    function automatic int cnt_w(int a, int b, int c, int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/spi_host_master_if.sv
// Request/response bundle between a requester and the SPI host master.
// master: requester side; slave: the spi_host_master itself.
interface spi_host_master_if #(
    parameter int XLEN = 32
);

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_data;
    logic            req_hold_cs;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            busy;

    modport master (
        output req_valid, req_data, req_hold_cs,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_data, req_hold_cs,
        output req_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/spi_host_master_clkgen.sv
// SCLK divider: CLK_DIV clk_i cycles per half-period, idle low.
// Ports: en_i runs it; rise_o/fall_o strobe on the cycle before the edge.
module spi_host_clkgen
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o,
    output logic sclk_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    assign wrap   = (div_q == DW'(CLK_DIV - 1));
    // Strobes mark the clk_i edge at which sclk toggles
    assign rise_o = en_i && wrap && !sclk_q;
    assign fall_o = en_i && wrap && sclk_q;
    assign sclk_o = sclk_q;

    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (wrap) begin
            div_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_host_master.sv
// SPI mode-0 initiator, MSB first, full duplex, optional CS bursts.
// Ports: clk_i/rst_ni, req/rsp bundle (bus), sclk_o/cs_o/mosi_o/miso_i.
module spi_host_master
    import spi_host_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    spi_host_master_if.slave     bus,
    output logic                 sclk_o,
    output logic                 cs_o,
    output logic                 mosi_o,
    input  logic                 miso_i
);

    localparam int CW = cnt_w(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP);
    localparam int BW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [XLEN-1:0] tx_q, tx_d;
    logic [XLEN-1:0] rx_q, rx_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            hold_q, hold_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            ready_q, ready_d;
    logic            accept;
    logic            rise, fall;

    spi_host_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (state_q == ST_SHIFT),
        .rise_o (rise),
        .fall_o (fall),
        .sclk_o (sclk_o)
    );

    assign accept        = bus.req_valid && ready_q;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign cs_o          = (state_q == ST_IDLE) || (state_q == ST_GAP);
    assign mosi_o        = cs_o ? 1'b0 : tx_q[XLEN-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        hold_d      = hold_q;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = bus.req_data;
                    hold_d  = bus.req_hold_cs;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHIFT: begin
                if (rise) begin
                    rx_d = {rx_q[XLEN-2:0], miso_i};
                end
                if (fall) begin
                    if (bit_q == BW'(XLEN - 1)) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BW'(1);
                        tx_d  = {tx_q[XLEN-2:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(CS_HOLD - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                    cnt_d       = '0;
                    state_d     = hold_q ? ST_LINGER : ST_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LINGER: begin
                // CS already low: go straight to shifting
                if (accept) begin
                    state_d = ST_SHIFT;
                    bit_d   = '0;
                    tx_d    = bus.req_data;
                    hold_d  = bus.req_hold_cs;
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(CS_GAP - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE) || (state_d == ST_LINGER);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            hold_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            hold_q      <= hold_d;
            rsp_valid_q <= rsp_valid_d;
            ready_q     <= ready_d;
        end
    end

endmodule
